// File: rtl/sp_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_arbiter_if
// Purpose  : Bundles the two requester ports and the single-port RAM pins
//            served by sp_ram_arbiter.
// Ports    : a_*/b_*  requester A/B handshake (req, wr, addr, wdata in;
//                     gnt, done, err, rdata out of the arbiter)
//            ram_*    RAM chip select, direction strobes, address, write data
//                     with output enable, and sampled read data
// Modports : slave  - arbiter side
//            master - requesters / RAM side
// Revision : 1.0 - initial release
// ============================================================================
interface sp_ram_arbiter_if #(
  parameter int ADDR  = 4,
  parameter int WIDTH = 8
);
  logic             a_req;
  logic             a_wr;
  logic [ADDR-1:0]  a_addr;
  logic [WIDTH-1:0] a_wdata;
  logic             a_gnt;
  logic             a_done;
  logic             a_err;
  logic [WIDTH-1:0] a_rdata;

  logic             b_req;
  logic             b_wr;
  logic [ADDR-1:0]  b_addr;
  logic [WIDTH-1:0] b_wdata;
  logic             b_gnt;
  logic             b_done;
  logic             b_err;
  logic [WIDTH-1:0] b_rdata;

  logic             ram_cs;
  logic             ram_wr_rd;
  logic             ram_op_en;
  logic [ADDR-1:0]  ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_oe;
  logic [WIDTH-1:0] ram_rdata;

  modport slave (
    input  a_req, a_wr, a_addr, a_wdata,
    input  b_req, b_wr, b_addr, b_wdata,
    input  ram_rdata,
    output a_gnt, a_done, a_err, a_rdata,
    output b_gnt, b_done, b_err, b_rdata,
    output ram_cs, ram_wr_rd, ram_op_en, ram_addr, ram_wdata, ram_oe
  );

  modport master (
    output a_req, a_wr, a_addr, a_wdata,
    output b_req, b_wr, b_addr, b_wdata,
    output ram_rdata,
    input  a_gnt, a_done, a_err, a_rdata,
    input  b_gnt, b_done, b_err, b_rdata,
    input  ram_cs, ram_wr_rd, ram_op_en, ram_addr, ram_wdata, ram_oe
  );
endinterface
`default_nettype wire

// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_arbiter
// Purpose  : Arbitrates two requesters onto one single-port RAM. Each
//            transaction runs IDLE -> ACCESS -> RESP (3 cycles); all outputs
//            are registered. Addresses >= DEPTH never reach the RAM and are
//            answered with done + err.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            bus    - sp_ram_arbiter_if.slave (requester A/B and RAM pins)
// Options  : SP_RAM_ARB_FIXED_PRIO_EN - when defined, A always wins
//            simultaneous requests and no last-served pointer exists;
//            otherwise contention is resolved round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module sp_ram_arbiter #(
  parameter int ADDR  = 4,
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sp_ram_arbiter_if.slave    bus
);

  localparam logic [ADDR:0] DEPTH_W = DEPTH[ADDR:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e           state_q;
  logic             win_b_q;      // current transaction belongs to B
  logic             wr_q;
  logic             oor_q;        // latched address is out of range
`ifndef SP_RAM_ARB_FIXED_PRIO_EN
  logic             last_b_q;     // B was served most recently
`endif

  logic             a_gnt_q, b_gnt_q;
  logic             a_done_q, b_done_q;
  logic             a_err_q, b_err_q;
  logic [WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic             ram_cs_q, ram_wr_rd_q, ram_op_en_q, ram_oe_q;
  logic [ADDR-1:0]  ram_addr_q;
  logic [WIDTH-1:0] ram_wdata_q;

  logic             pick_b_d;
  logic             wr_d;
  logic [ADDR-1:0]  addr_d;
  logic [WIDTH-1:0] wdata_d;
  logic             oor_d;

  // Winner selection and mux of the winner's request fields.
  always_comb begin
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    pick_b_d = bus.b_req & ~bus.a_req;
`else
    // Under contention the requester not served last takes the slot.
    pick_b_d = bus.b_req & (~bus.a_req | ~last_b_q);
`endif
    wr_d    = pick_b_d ? bus.b_wr    : bus.a_wr;
    addr_d  = pick_b_d ? bus.b_addr  : bus.a_addr;
    wdata_d = pick_b_d ? bus.b_wdata : bus.a_wdata;
    oor_d   = {1'b0, addr_d} >= DEPTH_W;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_b_q     <= 1'b0;
      wr_q        <= 1'b0;
      oor_q       <= 1'b0;
`ifndef SP_RAM_ARB_FIXED_PRIO_EN
      last_b_q    <= 1'b1;
`endif
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      ram_cs_q    <= 1'b0;
      ram_wr_rd_q <= 1'b0;
      ram_op_en_q <= 1'b1;
      ram_oe_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      a_gnt_q  <= 1'b0;
      b_gnt_q  <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      a_err_q  <= 1'b0;
      b_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.a_req || bus.b_req) begin
            state_q     <= ACCESS;
            win_b_q     <= pick_b_d;
            wr_q        <= wr_d;
            oor_q       <= oor_d;
`ifndef SP_RAM_ARB_FIXED_PRIO_EN
            last_b_q    <= pick_b_d;
`endif
            a_gnt_q     <= ~pick_b_d;
            b_gnt_q     <= pick_b_d;
            // Out-of-range accesses keep the RAM deselected and undriven.
            ram_cs_q    <= ~oor_d;
            ram_oe_q    <= wr_d & ~oor_d;
            ram_wr_rd_q <= wr_d;
            ram_op_en_q <= ~wr_d;
            ram_addr_q  <= addr_d;
            ram_wdata_q <= wdata_d;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          // RAM drove read data on the falling edge inside ACCESS.
          if (!oor_q && !wr_q) begin
            if (win_b_q) b_rdata_q <= bus.ram_rdata;
            else         a_rdata_q <= bus.ram_rdata;
          end
          a_done_q    <= ~win_b_q;
          b_done_q    <= win_b_q;
          a_err_q     <= ~win_b_q & oor_q;
          b_err_q     <= win_b_q & oor_q;
          ram_cs_q    <= 1'b0;
          ram_oe_q    <= 1'b0;
          ram_wr_rd_q <= 1'b0;
          ram_op_en_q <= 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.a_gnt     = a_gnt_q;
  assign bus.b_gnt     = b_gnt_q;
  assign bus.a_done    = a_done_q;
  assign bus.b_done    = b_done_q;
  assign bus.a_err     = a_err_q;
  assign bus.b_err     = b_err_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.ram_cs    = ram_cs_q;
  assign bus.ram_wr_rd = ram_wr_rd_q;
  assign bus.ram_op_en = ram_op_en_q;
  assign bus.ram_oe    = ram_oe_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_ram_arbiter
// Purpose  : Self-checking bench for sp_ram_arbiter with a behavioural RAM
//            and a transaction-level reference model (memory image, expected
//            read registers, last-served requester).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_ram_arbiter;
  localparam int ADDR  = 4;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  // {a_gnt,b_gnt,a_done,b_done,a_err,b_err,ram_cs,ram_oe,ram_wr_rd,ram_op_en}
  localparam logic [9:0] IDLE_FLAGS = 10'b0000000001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sp_ram_arbiter_if #(.ADDR(ADDR), .WIDTH(WIDTH)) bus ();

  sp_ram_arbiter #(.ADDR(ADDR), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [9:0] w_flags;
  assign w_flags = {bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done, bus.a_err,
                    bus.b_err, bus.ram_cs, bus.ram_oe, bus.ram_wr_rd, bus.ram_op_en};

  // Behavioural single-port RAM: write on rising edge, read on falling edge.
  // The data pin carries garbage whenever nobody drives it.
  logic [WIDTH-1:0] mem [0:15];
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_wr_rd)
      mem[bus.ram_addr] <= bus.ram_oe ? bus.ram_wdata : WIDTH'($urandom);
  end
  always @(negedge clk) begin
    if (bus.ram_cs && bus.ram_op_en && !bus.ram_wr_rd)
      bus.ram_rdata <= mem[bus.ram_addr];
    else
      bus.ram_rdata <= WIDTH'($urandom);
  end

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [WIDTH-1:0] ref_mem [0:15];
  logic [WIDTH-1:0] exp_a;
  logic [WIDTH-1:0] exp_b;
  bit               ref_last_b;

  // Exclusivity of per-requester outputs and no RAM select out of range.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((bus.a_gnt && bus.b_gnt) || (bus.a_done && bus.b_done) || (bus.a_err && bus.b_err)) begin
        errors++;
        $display("FAIL exclusive: gnt=%b%b done=%b%b err=%b%b, required no pair both high",
                 bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done, bus.a_err, bus.b_err);
      end
      checks++;
      if (bus.ram_cs && (int'(bus.ram_addr) >= DEPTH)) begin
        errors++;
        $display("FAIL cs_range: ram_cs=1 at addr %0d, required cs=0 for addr >= %0d",
                 bus.ram_addr, DEPTH);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_a      = '0;
    exp_b      = '0;
    ref_last_b = 1'b1;
  endtask

  // Who wins given the requesters present.
  function automatic bit model_pick_b(bit ra, bit rb);
    if (ra && !rb) return 1'b0;
    if (rb && !ra) return 1'b1;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return !ref_last_b;
`endif
  endfunction

  task automatic model_commit(bit is_b, bit wr, logic [ADDR-1:0] addr, logic [WIDTH-1:0] data);
    if (int'(addr) < DEPTH) begin
      if (wr)        ref_mem[addr] = data;
      else if (is_b) exp_b = ref_mem[addr];
      else           exp_a = ref_mem[addr];
    end
    ref_last_b = is_b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (w_flags !== IDLE_FLAGS) begin
      errors++; $display("FAIL reset_flags: got %b required %b", w_flags, IDLE_FLAGS);
    end
    checks++;
    if ({bus.ram_addr, bus.ram_wdata} !== '0) begin
      errors++; $display("FAIL reset_ram_bus: addr=%h wdata=%h required 0", bus.ram_addr, bus.ram_wdata);
    end
    checks++;
    if ({bus.a_rdata, bus.b_rdata} !== '0) begin
      errors++; $display("FAIL reset_rdata: a=%h b=%h required 0", bus.a_rdata, bus.b_rdata);
    end
    rst_n = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_write_read();
    // Cycle 0: A writes 0xA5 to address 3.
    bus.a_req = 1'b1; bus.a_wr = 1'b1; bus.a_addr = 4'd3; bus.a_wdata = 8'hA5;
    step();
    // Cycle 1: A's request fields are now don't-care; B requests and must wait.
    bus.a_req = 1'b0; bus.a_wr = 1'b0; bus.a_addr = 4'hF; bus.a_wdata = 8'h5A;
    bus.b_req = 1'b1; bus.b_wr = 1'b0; bus.b_addr = 4'd3; bus.b_wdata = 8'h00;
    checks++;
    if (w_flags !== 10'b1000001110) begin
      errors++; $display("FAIL wr_access_flags: got %b required %b", w_flags, 10'b1000001110);
    end
    checks++;
    if (bus.ram_addr !== 4'd3 || bus.ram_wdata !== 8'hA5) begin
      errors++; $display("FAIL wr_access_bus: addr=%h wdata=%h required 3/a5", bus.ram_addr, bus.ram_wdata);
    end
    step();
    // Cycle 2: A done.
    model_commit(1'b0, 1'b1, 4'd3, 8'hA5);
    checks++;
    if (w_flags !== 10'b0010000001) begin
      errors++; $display("FAIL wr_resp_flags: got %b required %b", w_flags, 10'b0010000001);
    end
    step();
    // Cycle 3: idle, B still waiting.
    checks++;
    if (w_flags !== IDLE_FLAGS) begin
      errors++; $display("FAIL wait_idle: got %b required %b", w_flags, IDLE_FLAGS);
    end
    step();
    // Cycle 4: B read granted.
    bus.b_req = 1'b0;
    checks++;
    if (w_flags !== 10'b0100001001 || bus.ram_addr !== 4'd3) begin
      errors++; $display("FAIL rd_access: flags=%b addr=%h required %b/3", w_flags, bus.ram_addr, 10'b0100001001);
    end
    step();
    model_commit(1'b1, 1'b0, 4'd3, 8'h00);
    checks++;
    if (w_flags !== 10'b0001000001) begin
      errors++; $display("FAIL rd_resp_flags: got %b required %b", w_flags, 10'b0001000001);
    end
    checks++;
    if (bus.b_rdata !== 8'hA5 || bus.a_rdata !== exp_a) begin
      errors++; $display("FAIL rd_data: b=%h a=%h required a5/%h", bus.b_rdata, bus.a_rdata, exp_a);
    end
    step();
  endtask

  task automatic test_out_of_range();
    // Load a_rdata with a known value first, then show an out-of-range read keeps it.
    bus.a_req = 1'b1; bus.a_wr = 1'b0; bus.a_addr = 4'd3;
    step();
    bus.a_req = 1'b0;
    step();
    model_commit(1'b0, 1'b0, 4'd3, 8'h00);
    checks++;
    if (bus.a_rdata !== exp_a) begin
      errors++; $display("FAIL oor_preload: a_rdata=%h required %h", bus.a_rdata, exp_a);
    end
    step();
    bus.a_req = 1'b1; bus.a_wr = 1'b0; bus.a_addr = 4'd9;
    step();
    bus.a_req = 1'b0;
    checks++;
    if (bus.a_gnt !== 1'b1 || bus.ram_cs !== 1'b0 || bus.ram_oe !== 1'b0) begin
      errors++; $display("FAIL oor_access: gnt=%b cs=%b oe=%b required 1/0/0", bus.a_gnt, bus.ram_cs, bus.ram_oe);
    end
    step();
    model_commit(1'b0, 1'b0, 4'd9, 8'h00);
    checks++;
    if (bus.a_done !== 1'b1 || bus.a_err !== 1'b1 || bus.a_rdata !== exp_a || bus.ram_cs !== 1'b0) begin
      errors++; $display("FAIL oor_resp: done=%b err=%b rdata=%h cs=%b required 1/1/%h/0",
                         bus.a_done, bus.a_err, bus.a_rdata, bus.ram_cs, exp_a);
    end
    step();
    checks++;
    if (w_flags !== IDLE_FLAGS) begin
      errors++; $display("FAIL oor_after: got %b required %b", w_flags, IDLE_FLAGS);
    end
  endtask

  task automatic test_round_robin();
    bit win_b;
    logic [ADDR-1:0] win_addr;
    win_b = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    bus.a_req = 1'b1; bus.a_wr = 1'b0; bus.a_addr = 4'd3;
    bus.b_req = 1'b1; bus.b_wr = 1'b0; bus.b_addr = 4'd1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 12) begin
        bus.a_req = 1'b0; bus.b_req = 1'b0;
      end
      if (c % 3 == 1) begin
        win_b = model_pick_b(1'b1, 1'b1);
        checks++;
        if ({bus.a_gnt, bus.b_gnt} !== {~win_b, win_b}) begin
          errors++; $display("FAIL rr_grant c%0d: gnt(a,b)=%b%b required %b%b",
                             c, bus.a_gnt, bus.b_gnt, ~win_b, win_b);
        end
      end else begin
        checks++;
        if ({bus.a_gnt, bus.b_gnt} !== 2'b00) begin
          errors++; $display("FAIL rr_nogrant c%0d: gnt(a,b)=%b%b required 00", c, bus.a_gnt, bus.b_gnt);
        end
      end
      if (c % 3 == 2) begin
        win_addr = win_b ? 4'd1 : 4'd3;
        model_commit(win_b, 1'b0, win_addr, 8'h00);
        checks++;
        if (bus.a_rdata !== exp_a || bus.b_rdata !== exp_b) begin
          errors++; $display("FAIL rr_rdata c%0d: a=%h b=%h required %h/%h", c, bus.a_rdata, bus.b_rdata, exp_a, exp_b);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    bus.a_req = 1'b0;
    bus.b_req = 1'b1; bus.b_wr = 1'b1; bus.b_addr = 4'd5; bus.b_wdata = 8'h3C;
    step();
    bus.b_req = 1'b0;
    checks++;
    if (bus.b_gnt !== 1'b1 || bus.ram_cs !== 1'b1) begin
      errors++; $display("FAIL mid_access: b_gnt=%b cs=%b required 1/1", bus.b_gnt, bus.ram_cs);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (w_flags !== IDLE_FLAGS || {bus.ram_addr, bus.ram_wdata, bus.a_rdata, bus.b_rdata} !== '0) begin
      errors++; $display("FAIL mid_async_reset: flags=%b addr=%h wdata=%h a=%h b=%h required %b/0/0/0/0",
                         w_flags, bus.ram_addr, bus.ram_wdata, bus.a_rdata, bus.b_rdata, IDLE_FLAGS);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (w_flags !== IDLE_FLAGS) begin
        errors++; $display("FAIL mid_no_done %0d: flags=%b required %b", i, w_flags, IDLE_FLAGS);
      end
    end
    bus.b_req = 1'b1; bus.b_wr = 1'b0; bus.b_addr = 4'd5;
    step();
    bus.b_req = 1'b0;
    step();
    model_commit(1'b1, 1'b0, 4'd5, 8'h00);
    checks++;
    if (bus.b_rdata !== exp_b || bus.b_rdata === 8'h3C) begin
      errors++; $display("FAIL mid_readback: b_rdata=%h required %h (never 3c)", bus.b_rdata, exp_b);
    end
    step();
  endtask

  task automatic test_random();
    bit ra, rb, wa, wb, win_b, wr, inr;
    logic [ADDR-1:0]  addr;
    logic [WIDTH-1:0] data;
    for (int n = 0; n < 60; n++) begin
      ra = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
      wa = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
      bus.a_req = ra; bus.a_wr = wa; bus.a_addr = ADDR'($urandom_range(0, 11)); bus.a_wdata = WIDTH'($urandom);
      bus.b_req = rb; bus.b_wr = wb; bus.b_addr = ADDR'($urandom_range(0, 11)); bus.b_wdata = WIDTH'($urandom);
      if (!ra && !rb) begin
        step();
        checks++;
        if (w_flags !== IDLE_FLAGS) begin
          errors++; $display("FAIL rnd_idle %0d: flags=%b required %b", n, w_flags, IDLE_FLAGS);
        end
        continue;
      end
      win_b = model_pick_b(ra, rb);
      wr    = win_b ? wb : wa;
      addr  = win_b ? bus.b_addr : bus.a_addr;
      data  = win_b ? bus.b_wdata : bus.a_wdata;
      inr   = int'(addr) < DEPTH;
      step();
      bus.a_req = 1'b0; bus.b_req = 1'b0;
      bus.a_wr = ~wa; bus.b_wr = ~wb;
      bus.a_addr = ~bus.a_addr; bus.b_addr = ~bus.b_addr;
      bus.a_wdata = ~bus.a_wdata; bus.b_wdata = ~bus.b_wdata;
      checks++;
      if ({bus.a_gnt, bus.b_gnt} !== {~win_b, win_b} || {bus.ram_cs, bus.ram_oe} !== {inr, inr & wr}) begin
        errors++; $display("FAIL rnd_access %0d: gnt=%b%b cs/oe=%b%b required %b%b/%b%b",
                           n, bus.a_gnt, bus.b_gnt, bus.ram_cs, bus.ram_oe, ~win_b, win_b, inr, inr & wr);
      end
      checks++;
      if (bus.ram_addr !== addr || bus.ram_wdata !== data) begin
        errors++; $display("FAIL rnd_bus %0d: addr=%h wdata=%h required %h/%h", n, bus.ram_addr, bus.ram_wdata, addr, data);
      end
      if (inr) begin
        checks++;
        if ({bus.ram_wr_rd, bus.ram_op_en} !== {wr, ~wr}) begin
          errors++; $display("FAIL rnd_dir %0d: wr_rd/op_en=%b%b required %b%b", n, bus.ram_wr_rd, bus.ram_op_en, wr, ~wr);
        end
      end
      step();
      model_commit(win_b, wr, addr, data);
      checks++;
      if ({bus.a_done, bus.b_done, bus.a_err, bus.b_err} !== {~win_b, win_b, ~win_b & ~inr, win_b & ~inr}) begin
        errors++; $display("FAIL rnd_resp %0d: done=%b%b err=%b%b required %b%b/%b%b", n, bus.a_done, bus.b_done,
                           bus.a_err, bus.b_err, ~win_b, win_b, ~win_b & ~inr, win_b & ~inr);
      end
      checks++;
      if (bus.a_rdata !== exp_a || bus.b_rdata !== exp_b) begin
        errors++; $display("FAIL rnd_rdata %0d: a=%h b=%h required %h/%h", n, bus.a_rdata, bus.b_rdata, exp_a, exp_b);
      end
      step();
      checks++;
      if (w_flags !== IDLE_FLAGS) begin
        errors++; $display("FAIL rnd_end %0d: flags=%b required %b", n, w_flags, IDLE_FLAGS);
      end
    end
  endtask

  initial begin
    bus.a_req = 1'b0; bus.a_wr = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_wr = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    test_reset();
    test_write_read();
    test_out_of_range();
    test_round_robin();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sp_ram_arbiter.md
SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 Parameter ADDR, default 4: address width in bits for both requesters and the RAM.
REQ-002 Parameter DEPTH, default 8: number of valid RAM words; legal addresses are 0..DEPTH-1.
REQ-003 Parameter WIDTH, default 8: data width in bits.
REQ-004 Port clk  in  1: single clock; all state SHALL update on the rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous assertion, active-low.
REQ-006 Ports a_req/b_req  in  1: requester A/B transaction request.
REQ-007 Ports a_wr/b_wr  in  1: 1 = write, 0 = read.
REQ-008 Ports a_addr/b_addr  in  ADDR: requester word address.
REQ-009 Ports a_wdata/b_wdata  in  WIDTH: requester write data.
REQ-010 Ports a_gnt/b_gnt  out  1: one-cycle pulse, the requester's transaction is on the RAM.
REQ-011 Ports a_done/b_done  out  1: one-cycle pulse, the transaction has completed.
REQ-012 Ports a_err/b_err  out  1: qualifies done; 1 = address out of range.
REQ-013 Ports a_rdata/b_rdata  out  WIDTH: read result, held until that port's next successful read.
REQ-014 Port ram_cs  out  1: RAM chip select.
REQ-015 Port ram_wr_rd  out  1: 1 = write, 0 = read.
REQ-016 Port ram_op_en  out  1: 1 = read, 0 = write.
REQ-017 Port ram_addr  out  ADDR: RAM address.
REQ-018 Ports ram_wdata  out  WIDTH, and ram_oe  out  1: write data and its output enable; top level drives the RAM data pin with ram_wdata when ram_oe=1, otherwise high-Z.
REQ-019 Port ram_rdata  in  WIDTH: RAM data pin, sampled by this block.

Function
REQ-020 The FSM SHALL have the states IDLE, ACCESS and RESP; IDLE->ACCESS on any sampled request, ACCESS->RESP always, RESP->IDLE always; one transaction takes 3 cycles.
REQ-021 In IDLE with a request present, the arbiter SHALL select a winner and latch its wr, addr and wdata at that edge; requester inputs are don't-care after that edge.
REQ-022 Arbitration SHALL be round-robin: if only one requester is active, it wins; if both are active, the winner is the requester not served last; the last-served pointer resets to B.
REQ-023 In ACCESS: winner gnt=1; ram_cs=1; ram_addr=latched addr; ram_wr_rd=wr; ram_op_en=~wr; ram_oe=wr; ram_wdata=latched wdata.
REQ-024 A write SHALL commit to the RAM at the rising edge that ends ACCESS.
REQ-025 A read SHALL capture ram_rdata into the winner's rdata register at the rising edge that ends ACCESS; the RAM's falling-edge read falls within ACCESS.
REQ-026 In RESP: winner done=1 and err=0; for reads, rdata is valid in the same cycle.
REQ-027 If the latched addr >= DEPTH, ACCESS SHALL keep ram_cs=0 and ram_oe=0; RESP pulses done with err=1; rdata is unchanged.
REQ-028 Outside ACCESS: ram_cs=0, ram_oe=0, ram_wr_rd=0, ram_op_en=1; ram_addr and ram_wdata hold their last values.
REQ-029 gnt, done and err are never asserted for both requesters in the same cycle.
REQ-030 Requests present during ACCESS or RESP SHALL wait; they are sampled only in IDLE.

Reset
REQ-031 When rst_n=0, the block SHALL immediately force: state=IDLE; all gnt, done, err=0; ram_cs, ram_oe, ram_wr_rd=0; ram_op_en=1; ram_addr, ram_wdata, a_rdata, b_rdata=0; last-served pointer=B.
REQ-032 If reset is asserted during ACCESS or RESP, the in-flight transaction SHALL be discarded with no done pulse; a write discarded before its commit edge does not reach the RAM.

Configuration
REQ-033 Macro SP_RAM_ARB_FIXED_PRIO_EN: when defined, requester A always wins simultaneous requests and the last-served pointer is not implemented; when undefined, round-robin per REQ-022 applies.

Verification
REQ-034 Reset, then A writes 0xA5 to addr 3 -> a_gnt at cycle 1 with ram_cs=1, ram_wr_rd=1, ram_oe=1, ram_addr=3; a_done at cycle 2 with a_err=0.
REQ-035 B reads addr 3 after REQ-034 -> b_gnt with ram_op_en=1, ram_oe=0; b_done with b_rdata=0xA5; a_rdata unchanged.
REQ-036 A and B request continuously, without the macro -> grants are A, B, A, B, spaced 3 cycles apart; with the macro -> A, A, A.
REQ-037 A reads addr 9 with DEPTH=8 -> ram_cs stays 0 throughout; a_done=1 with a_err=1; a_rdata is unchanged.
REQ-038 rst_n pulsed low during the ACCESS of a B write of 0x3C to addr 5 -> no b_done; all outputs at reset values; a later read of addr 5 does not return 0x3C.
